// File: rtl/half_pkg.sv
// -----------------------------------------------------------------------------
// half_pkg
//   Shared definitions for the half-precision (IEEE binary16) stream blocks.
//
//   Contents:
//     HALF_EXP_W / HALF_MAN_W / HALF_W : binary16 field widths
//     half_t                           : one binary16 value
//     half_beat_t                      : one stream beat (valid, last, data)
//     IDLE / STREAM                    : serializer state values; the state
//                                        register is the out_valid bit itself
//     is_subnormal()                   : exponent == 0 and mantissa != 0
//     flush_subnormal()                : subnormal -> signed zero, else pass
// -----------------------------------------------------------------------------
package half_pkg;

  localparam int HALF_EXP_W = 5;
  localparam int HALF_MAN_W = 10;
  localparam int HALF_W     = 1 + HALF_EXP_W + HALF_MAN_W;

  typedef logic [15:0] half_t;

  // Beat format common to every stream producer/consumer in the datapath.
  typedef struct packed {
    logic  valid;
    logic  last;
    half_t data;
  } half_beat_t;

  // A burst is "in flight" exactly when out_valid is high, so one bit of
  // state is enough; these name its two values.
  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;

  function automatic logic is_subnormal(input half_t x);
    return (x[HALF_W-2 -: HALF_EXP_W] == '0) && (x[HALF_MAN_W-1:0] != '0);
  endfunction

  // The sign bit survives so that negative subnormals become -0.
  function automatic half_t flush_subnormal(input half_t x);
    return is_subnormal(x) ? {x[HALF_W-1], {(HALF_W-1){1'b0}}} : x;
  endfunction

endpackage

// File: rtl/half_ftz.sv
// -----------------------------------------------------------------------------
// half_ftz
//   Combinational flush-to-zero for one binary16 value. Subnormal inputs
//   (exponent == 0, mantissa != 0) are replaced by a zero carrying the same
//   sign; every other encoding, including zeros, infinities and NaNs, passes
//   through bit-exact.
//
//   Ports:
//     din   in   half_t   raw value
//     dout  out  half_t   flushed value
// -----------------------------------------------------------------------------
module half_ftz
  import half_pkg::*;
(
  input  half_t din,
  output half_t dout
);

  assign dout = flush_subnormal(din);

endmodule

// File: rtl/half_stream_serialize.sv
// -----------------------------------------------------------------------------
// half_stream_serialize
//   Parallel-to-stream source. Takes one vector of LENGTH binary16 values in a
//   single valid/ready handshake and emits it as a gap-free burst of LENGTH
//   beats, element 0 first, one per clock. Data is forced to zero whenever
//   out_valid is low. A new vector may be accepted on the last beat of the
//   current burst, which makes back-to-back bursts contiguous.
//
//   Build option:
//     HALF_STREAM_SERIALIZE_FTZ_EN  when defined, subnormal elements are
//                                   flushed to signed zero on their way to c.
//                                   The stored vector always stays raw.
//
//   Parameters:
//     BITS    element width, must be 16
//     LENGTH  elements per vector / beats per burst, >= 1
//
//   Ports:
//     clk        in   1            rising-edge clock
//     rst        in   1            synchronous active-high reset
//     in_valid   in   1            vector a is offered
//     in_ready   out  1            a vector can be taken this cycle
//     a          in   LENGTH*BITS  element i at a[i*BITS +: BITS]
//     out_valid  out  1            beat valid (registered)
//     c          out  BITS         beat data, 0 when idle (registered)
//     out_last   out  1            final beat of the burst
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | out_valid = 0, c = 0, waiting for a vector
//   STREAM| out_valid = 1, c = element idx of the stored vector
// -----------------------------------------------------------------------------
module half_stream_serialize
  import half_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LENGTH*BITS-1:0] a,
  output logic                   out_valid,
  output logic [BITS-1:0]        c,
  output logic                   out_last
);

  localparam int              IDX_W    = $clog2(LENGTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

  logic [LENGTH*BITS-1:0] vec_buf;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_inc;
  logic                   accept;
  half_t                  raw_next;
  half_t                  beat_next;

  // out_valid doubles as the state bit; out_last is only meaningful while
  // a burst is in flight.
  assign out_last = (out_valid == STREAM) && (idx == LAST_IDX);

  // Ready depends on state and reset only, never on in_valid, so upstream
  // can drive in_valid from in_ready without a combinational loop.
  assign in_ready = !rst && ((out_valid == IDLE) || out_last);
  assign accept   = in_valid && in_ready;
  assign idx_inc  = idx + IDX_W'(1);

  // Source of the next beat: element 0 of the incoming vector on a load,
  // otherwise the following element of the stored vector. When idx sits on
  // the last element idx_inc matches nothing; that value is never used
  // because the burst either reloads or goes idle.
  always_comb begin
    raw_next = a[BITS-1:0];
    if (!accept) begin
      for (int i = 0; i < LENGTH; i++) begin
        if (idx_inc == IDX_W'(i)) raw_next = vec_buf[i*BITS +: BITS];
      end
    end
  end

`ifdef HALF_STREAM_SERIALIZE_FTZ_EN
  half_ftz u_ftz (
    .din  (raw_next),
    .dout (beat_next)
  );
`else
  assign beat_next = raw_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= IDLE;
      c         <= '0;
      idx       <= '0;
      vec_buf   <= '0;
    end else if (accept) begin
      // Load from IDLE or reload on the last beat; identical either way.
      vec_buf   <= a;
      idx       <= '0;
      out_valid <= STREAM;
      c         <= beat_next;
    end else if ((out_valid == STREAM) && !out_last) begin
      idx <= idx_inc;
      c   <= beat_next;
    end else begin
      out_valid <= IDLE;
      idx       <= '0;
      c         <= '0;
    end
  end

endmodule

// File: tb/tb_half_stream_serialize.sv
module tb_half_stream_serialize;

  logic        clk;
  logic        rst4, in_valid4, in_ready4, out_valid4, out_last4;
  logic [63:0] a4;
  logic [15:0] c4;
  logic        rst1, in_valid1, in_ready1, out_valid1, out_last1;
  logic [15:0] a1;
  logic [15:0] c1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q4[$];
  logic [15:0] q1[$];

  half_stream_serialize #(.BITS(16), .LENGTH(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .out_valid(out_valid4), .c(c4), .out_last(out_last4)
  );

  half_stream_serialize #(.BITS(16), .LENGTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .out_valid(out_valid1), .c(c1), .out_last(out_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat value for a raw element, written straight from the format
  // rule: exponent field zero with nonzero mantissa becomes a signed zero.
  function automatic logic [15:0] exp_elem(input logic [15:0] x);
`ifdef HALF_STREAM_SERIALIZE_FTZ_EN
    if (x[14:10] == 5'd0 && x[9:0] != 10'd0) return {x[15], 15'd0};
`endif
    return x;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 3) == 0) v[14:10] = 5'd0;
    return v;
  endfunction

  // Reference model: a queue of beats still owed. The front is what should be
  // on c this cycle; a vector can be taken when at most one beat is owed.
  task automatic step4(input logic r, input logic v, input logic [63:0] vec, output logic acc);
    logic rdy;
    @(negedge clk);
    chk("len4_valid", out_valid4, q4.size() > 0);
    chk("len4_data",  c4, (q4.size() > 0) ? q4[0] : 16'h0);
    chk("len4_last",  out_last4, q4.size() == 1);
    rst4 = r; in_valid4 = v; a4 = vec;
    #1;
    rdy = !r && (q4.size() <= 1);
    chk("len4_ready", in_ready4, rdy);
    @(posedge clk);
    acc = v && rdy;
    if (r) q4.delete();
    else begin
      if (q4.size() > 0) void'(q4.pop_front());
      if (acc) for (int k = 0; k < 4; k++) q4.push_back(exp_elem(vec[k*16 +: 16]));
    end
  endtask

  task automatic step1(input logic r, input logic v, input logic [15:0] vec, output logic acc);
    logic rdy;
    @(negedge clk);
    chk("len1_valid", out_valid1, q1.size() > 0);
    chk("len1_data",  c1, (q1.size() > 0) ? q1[0] : 16'h0);
    chk("len1_last",  out_last1, q1.size() == 1);
    rst1 = r; in_valid1 = v; a1 = vec;
    #1;
    rdy = !r && (q1.size() <= 1);
    chk("len1_ready", in_ready1, rdy);
    @(posedge clk);
    acc = v && rdy;
    if (r) q1.delete();
    else begin
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc) q1.push_back(exp_elem(vec));
    end
  endtask

  // Offer vec until it is taken, bounded so a stuck in_ready cannot hang.
  task automatic offer4(input logic [63:0] vec);
    logic acc;
    int   n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 12) begin
      step4(1'b0, 1'b1, vec, acc);
      n++;
    end
    if (!acc) chk("len4_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_len4();
    logic acc;
    logic [63:0] v;
    @(posedge clk);
    for (int i = 0; i < 3; i++) step4(1'b1, 1'b0, 64'h0, acc);
    // directed burst: element 0 = 0x3C00 at the low bits
    step4(1'b0, 1'b1, 64'h4400_4200_4000_3C00, acc);
    chk("len4_first_accept", acc, 1'b1);
    for (int i = 0; i < 6; i++) step4(1'b0, 1'b0, 64'h0, acc);
    // back-to-back with in_valid held high
    offer4(64'h1111_2222_3333_4444);
    offer4(64'h5555_6666_7777_8888);
    for (int i = 0; i < 6; i++) step4(1'b0, 1'b0, 64'h0, acc);
    // pulse mid-burst must be ignored
    step4(1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, acc);
    step4(1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, acc);
    chk("len4_midburst_ignored", acc, 1'b0);
    for (int i = 0; i < 5; i++) step4(1'b0, 1'b0, 64'h0, acc);
    // reset mid-burst, then a clean restart
    step4(1'b0, 1'b1, 64'h4B00_4A00_4900_4800, acc);
    step4(1'b0, 1'b0, 64'h0, acc);
    step4(1'b1, 1'b1, 64'h0, acc);
    step4(1'b1, 1'b0, 64'h0, acc);
    step4(1'b0, 1'b1, 64'h5300_5200_5100_5000, acc);
    for (int i = 0; i < 5; i++) step4(1'b0, 1'b0, 64'h0, acc);
    // subnormal handling: 0x0001, 0x8200, 0x0400, 0x3C00
    step4(1'b0, 1'b1, 64'h3C00_0400_8200_0001, acc);
    for (int i = 0; i < 5; i++) step4(1'b0, 1'b0, 64'h0, acc);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) v[k*16 +: 16] = rand_half();
      step4($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, v, acc);
    end
    for (int i = 0; i < 5; i++) step4(1'b0, 1'b0, 64'h0, acc);
  endtask

  task automatic run_len1();
    logic acc;
    logic [15:0] seq [5];
    seq = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4200, 16'h4400};
    @(posedge clk);
    for (int i = 0; i < 2; i++) step1(1'b1, 1'b0, 16'h0, acc);
    for (int i = 0; i < 5; i++) begin
      step1(1'b0, 1'b1, seq[i], acc);
      chk("len1_accept_each", acc, 1'b1);
    end
    step1(1'b0, 1'b0, 16'h0, acc);
    step1(1'b0, 1'b1, 16'h8200, acc);
    step1(1'b0, 1'b1, 16'h0001, acc);
    for (int i = 0; i < 200; i++)
      step1($urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, rand_half(), acc);
    for (int i = 0; i < 3; i++) step1(1'b0, 1'b0, 16'h0, acc);
  endtask

  initial begin
    rst4 = 1'b1; in_valid4 = 1'b0; a4 = '0;
    rst1 = 1'b1; in_valid1 = 1'b0; a1 = '0;
    fork
      run_len4();
      run_len1();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/half_stream_serialize.md
# half_stream_serialize

Parallel-to-stream source for the half-precision neural-network datapath. It accepts one vector of LENGTH half-precision values in a single handshake and emits the values as a contiguous burst of LENGTH valid beats, one per clock. The burst format matches the input side of `half_stream_accumulate` and the other stream consumers: valid held high for exactly LENGTH consecutive cycles, with no gaps, and the data forced to zero when not valid.

## Interface
- BITS, 16, element width; must be 16 (IEEE binary16)
- LENGTH, 10, elements per vector / beats per burst; LENGTH >= 1
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  vector `a` is offered
- in_ready  output  1  block can take a vector this cycle
- a  input  LENGTH*BITS  vector; element i at a[i*BITS +: BITS]
- out_valid  output  1  beat valid
- c  output  BITS  beat data; 0 when out_valid=0
- out_last  output  1  high on final beat of burst (element LENGTH-1)

## Operation
- Registers:
  - buf (LENGTH*BITS) holds the vector.
  - idx (0..LENGTH-1, width $clog2(LENGTH)+1) is the beat index.
  - out_valid and c are registered.
- Accept = in_valid && in_ready, sampled at the rising edge.
- in_ready (combinational from state only, never from in_valid) = !rst && (!out_valid || out_last).
- States:
  - IDLE (out_valid=0): on accept, load buf<=a, c<=elem(a,0), idx<=0, out_valid<=1, go to STREAM. Otherwise hold with c=0.
  - STREAM, idx<LENGTH-1: idx<=idx+1, c<=elem(buf,idx+1). in_valid is ignored (in_ready=0).
  - STREAM, idx==LENGTH-1 (out_last=1):
    - On accept: reload exactly as from IDLE, giving back-to-back bursts with zero idle cycles.
    - Otherwise: out_valid<=0, c<=0, idx<=0, go to IDLE.
- Bursts are never interrupted. Once started, all LENGTH beats are emitted and no backpressure exists, so a consumer that counts valid beats stays aligned.
- LENGTH=1: every beat is last. in_ready=1 whenever not in reset, giving one vector per cycle.
- elem() passes data bits unmodified, except as described under Configuration.

## Timing
- Reset values: out_valid=0, c=0, out_last=0, idx=0, buf=0. in_ready=0 while rst=1.
- rst is dominant: asserted mid-burst, the burst is abandoned at that edge. The next cycle shows out_valid=0 and c=0, and no partial resume occurs.
- Latency: vector accepted at edge N puts element 0 on c during cycle N+1. Element k appears in cycle N+1+k. out_last is asserted in cycle N+LENGTH.
- Throughput: one vector per LENGTH cycles sustained.
- in_valid held high with a new vector accepted on each out_last cycle gives out_valid continuously high.

## Configuration
- HALF_STREAM_SERIALIZE_FTZ_EN defined: a subnormal element (exponent==0, mantissa!=0) is emitted as a signed zero that keeps the sign bit. For example, 0x0001 becomes 0x0000 and 0x8200 becomes 0x8000. Flushing applies at beat output, so buf holds raw data.
- Not defined: elements are emitted bit-exact, including subnormals.
- Latency and handshake are identical in both builds.

## Structure
- The shared package `half_pkg` holds:
  - HALF_EXP_W=5, HALF_MAN_W=10
  - typedef half_t (logic [15:0])
  - function is_subnormal(half_t)
  - The stream beat typedef, shared with other stream blocks.
- Sub-module `half_ftz` is the combinational flush-to-zero (half_t in, half_t out). It is instantiated under the macro; without the macro it is a wire.
- The state is the out_valid bit plus idx. No separate enum is needed beyond IDLE/STREAM localparams.

## Test plan
- LENGTH=4, reset 3 cycles, then a={0x4400,0x4200,0x4000,0x3C00} (elem0=0x3C00) -> c=0x3C00,0x4000,0x4200,0x4400 in cycles N+1..N+4; out_last only at N+4; then out_valid=0, c=0. Feeding the burst into `half_stream_accumulate` (LENGTH=4) -> sum 0x4900.
- Back-to-back: in_valid held high with two vectors -> 8 contiguous valid beats; in_ready high only on out_last and IDLE cycles; second vector accepted at the out_last edge.
- in_valid pulsed mid-burst with a different vector -> ignored; the current burst completes unchanged; the pulsed vector is never emitted.
- rst asserted at beat 2 of 4 -> out_valid=0, c=0 the next cycle, in_ready=0 during rst; a new vector after release starts cleanly at element 0.
- LENGTH=1, in_valid high for 5 cycles with values 0x3C00..0x4400 -> 5 consecutive beats, out_last=1 on each.
- FTZ build: elements 0x0001, 0x8200, 0x0400, 0x3C00 -> 0x0000, 0x8000, 0x0400, 0x3C00. Non-FTZ build -> bit-exact.
